// File: rtl/unsi_div_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package unsi_div_pkg;

  localparam int DW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // All-ones quotient reported for a zero divisor (2*dw bits wide).
  function automatic logic [31:0] div0_quo(input int dw);
    return (32'd1 << (2 * dw)) - 32'd1;
  endfunction

endpackage

// File: rtl/unsi_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module unsi_div_step
  import unsi_div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] pr,
  input  logic          bit_in,
  input  logic [DW-1:0] dvs,
  output logic [DW-1:0] pr_nxt,
  output logic          q_bit
);

  logic [DW:0]   sh;
  logic [DW-1:0] diff;

  assign sh     = {pr, bit_in};
  assign q_bit  = (sh >= {1'b0, dvs});
  // Difference always fits in DW bits when the trial succeeds.
  assign diff   = DW'(sh - {1'b0, dvs});
  assign pr_nxt = q_bit ? diff : sh[DW-1:0];

endmodule

// File: rtl/unsi_div_8b_4b_seq.sv
// Sequential unsigned restoring divider, 2*DW / DW, one quotient bit per cycle.
module unsi_div_8b_4b_seq
  import unsi_div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [2*DW-1:0] dvd,
  input  logic [DW-1:0]   dvs,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [2*DW-1:0] quo,
  output logic [DW-1:0]   rem,
  output logic            div0
);

  localparam int QW = 2 * DW;
  localparam int CW = $clog2(QW);
  localparam logic [QW-1:0] DIV0_QUO = QW'(div0_quo(DW));
  localparam logic [CW-1:0] CNT_INIT = CW'(QW - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [QW-1:0] sh_q, sh_d;
  logic [DW-1:0] pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          div0_q, div0_d;
  logic          vld_q, vld_d;

  logic [DW-1:0] pr_nx;
  logic          qb;

  unsi_div_step #(.DW(DW)) u_step (
    .pr     (pr_q),
    .bit_in (sh_q[QW-1]),
    .dvs    (dvs_q),
    .pr_nxt (pr_nx),
    .q_bit  (qb)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  always_comb begin
    state_d = state_q;
    dvs_d   = dvs_q;
    sh_d    = sh_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_vld) begin
          dvs_d = dvs;
          sh_d  = dvd;
          pr_d  = '0;
          cnt_d = CNT_INIT;
          if (dvs == '0) begin
            state_d = ST_DONE;
            quo_d   = DIV0_QUO;
            rem_d   = dvd[DW-1:0];
            div0_d  = 1'b1;
            vld_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            div0_d  = 1'b0;
          end
        end
      end
      ST_CALC: begin
        pr_d = pr_nx;
        sh_d = {sh_q[QW-2:0], qb};
        if (cnt_q == '0) begin
          quo_d   = {sh_q[QW-2:0], qb};
          rem_d   = pr_nx;
          vld_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_rdy) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvs_q   <= '0;
      sh_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvs_q   <= dvs_d;
      sh_q    <= sh_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      vld_q   <= vld_d;
    end
  end

  assign in_rdy  = (state_q == ST_IDLE);
  assign out_vld = vld_q;
  assign quo     = quo_q;
  assign rem     = rem_q;
  assign div0    = div0_q;

endmodule

// File: tb/tb_unsi_div_8b_4b_seq.sv
// Self-checking bench for unsi_div_8b_4b_seq.
module tb_unsi_div_8b_4b_seq;

  logic       clk;
  logic       rst_n;
  logic       in_vld;
  logic       in_rdy;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic       out_vld;
  logic       out_rdy;
  logic [7:0] quo;
  logic [3:0] rem;
  logic       div0;

  int n_chk;
  int n_fail;

  unsi_div_8b_4b_seq #(.DW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .dvd     (dvd),
    .dvs     (dvs),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .quo     (quo),
    .rem     (rem),
    .div0    (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] quo;
    logic [3:0] rem;
    logic       div0;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic with the zero-divisor rule.
  function automatic logic [11:0] ref_div(input logic [7:0] a,
                                          input logic [3:0] b);
    logic [7:0] q;
    logic [3:0] r;
    if (b == 4'd0) begin
      q = 8'hFF;
      r = a[3:0];
    end else begin
      q = 8'(int'(a) / int'(b));
      r = 4'(int'(a) % int'(b));
    end
    return {q, r};
  endfunction

  // Issue one operation; optional backpressure hold and busy-time noise.
  task automatic run_op(input string nm, input logic [7:0] a,
                        input logic [3:0] b, input logic [7:0] eq,
                        input logic [3:0] er, input logic ed,
                        input int lat, input int hold, input bit noise);
    int n;
    n = 0;
    while (!in_rdy && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " in_rdy before accept"}, 32'(in_rdy), 32'd1);
    in_vld = 1'b1;
    dvd = a;
    dvs = b;
    out_rdy = 1'b0;
    tick();
    if (noise) begin
      dvd = ~a;
      dvs = b + 4'd1;
    end else begin
      in_vld = 1'b0;
    end
    n = 0;
    while (!out_vld && n < 30) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat));
    for (int i = 0; i <= hold; i++) begin
      chk({nm, " out_vld"}, 32'(out_vld), 32'd1);
      chk({nm, " quo"}, 32'(quo), 32'(eq));
      chk({nm, " rem"}, 32'(rem), 32'(er));
      chk({nm, " div0"}, 32'(div0), 32'(ed));
      chk({nm, " in_rdy busy"}, 32'(in_rdy), 32'd0);
      if (i < hold) tick();
    end
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    in_vld = 1'b0;
    chk({nm, " out_vld after hs"}, 32'(out_vld), 32'd0);
    chk({nm, " in_rdy after hs"}, 32'(in_rdy), 32'd1);
  endtask

  vec_t vt[8];

  initial begin
    logic [11:0] r;
    int n;
    n_chk = 0;
    n_fail = 0;
    vt[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 8};
    vt[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8};
    vt[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0, 8};
    vt[3] = '{8'd13,  4'd0,  8'd255, 4'd13, 1'b1, 0};
    vt[4] = '{8'd64,  4'd8,  8'd8,   4'd0,  1'b0, 8};
    vt[5] = '{8'd0,   4'd1,  8'd0,   4'd0,  1'b0, 8};
    vt[6] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 8};
    vt[7] = '{8'd255, 4'd0,  8'd255, 4'd15, 1'b1, 0};

    rst_n = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b0;
    dvd = '0;
    dvs = '0;
    #12;
    chk("reset out_vld", 32'(out_vld), 32'd0);
    chk("reset quo", 32'(quo), 32'd0);
    chk("reset rem", 32'(rem), 32'd0);
    chk("reset div0", 32'(div0), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("reset in_rdy", 32'(in_rdy), 32'd1);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vt[i].dvd, vt[i].dvs, vt[i].quo,
             vt[i].rem, vt[i].div0, vt[i].lat, 0, 1'b0);

    run_op("backpressure", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, 6, 1'b1);

    in_vld = 1'b1;
    dvd = 8'd200;
    dvs = 4'd7;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_vld", 32'(out_vld), 32'd0);
    chk("midrst quo", 32'(quo), 32'd0);
    chk("midrst rem", 32'(rem), 32'd0);
    chk("midrst div0", 32'(div0), 32'd0);
    chk("midrst in_rdy", 32'(in_rdy), 32'd1);
    #3;
    rst_n = 1'b1;
    tick();
    chk("midrst in_rdy rel", 32'(in_rdy), 32'd1);
    chk("midrst out_vld rel", 32'(out_vld), 32'd0);
    run_op("post-reset", 8'd64, 4'd8, 8'd8, 4'd0, 1'b0, 8, 0, 1'b0);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        r = ref_div(8'(a), 4'(b));
        n = 0;
        while (!in_rdy && n < 40) begin
          out_rdy = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        if (!in_rdy) chk("sweep in_rdy timeout", 32'(in_rdy), 32'd1);
        in_vld = 1'b1;
        dvd = 8'(a);
        dvs = 4'(b);
        tick();
        in_vld = 1'b0;
        n = 0;
        while (!out_vld && n < 30) begin
          out_rdy = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        if (!out_vld || quo !== r[11:4] || rem !== r[3:0] ||
            div0 !== (b == 0)) begin
          n_chk++;
          n_fail++;
          $display("FAIL sweep %0d/%0d: got v=%0d q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
                   a, b, out_vld, quo, rem, div0, r[11:4], r[3:0], b == 0);
        end else begin
          n_chk++;
        end
        n = 0;
        out_rdy = 1'($urandom_range(0, 1));
        while (!out_rdy && n < 20) begin
          tick();
          out_rdy = 1'($urandom_range(0, 1));
          n++;
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
      end
    end
    chk("sweep final out_vld", 32'(out_vld), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
